// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Bit timing advances only on enable pulses; TICKS_PER_BIT pulses make one bit.
module uart_tx #(
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned TICKS_PER_BIT = 16,
    parameter int unsigned PARITY_EN     = 0,
    parameter int unsigned PARITY_ODD    = 0,
    parameter int unsigned STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned TW = $clog2(TICKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state_q;
    logic [TW-1:0]          tick_q;
    logic [3:0]             bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   parity_q;
    logic                   tx_q;
    logic                   bit_end;

    assign bit_end  = enable && (tick_q == TW'(TICKS_PER_BIT - 1));
    assign in_ready = (state_q == IDLE) && !rst;
    assign busy     = (state_q != IDLE);
    assign tx       = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            tick_q  <= '0;
            bit_q   <= '0;
        end else begin
            if (state_q != IDLE && enable)
                tick_q <= bit_end ? '0 : tick_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shift_q  <= in_data;
                        parity_q <= (^in_data) ^ (PARITY_ODD != 0);
                        tick_q   <= '0;
                        bit_q    <= '0;
                        state_q  <= START;
                        tx_q     <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        bit_q   <= '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_q == 4'(DATA_BITS - 1)) begin
                            bit_q <= '0;
                            if (PARITY_EN != 0) begin
                                state_q <= PARITY;
                                tx_q    <= parity_q;
                            end else begin
                                state_q <= STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
                STOP: begin
                    // bit_q counts stop bits already completed
                    if (bit_end) begin
                        if (bit_q == 4'(STOP_BITS - 1))
                            state_q <= IDLE;
                        else
                            bit_q <= bit_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule
